// File: rtl/alu_nbit_seq_if.sv
// Operand/opcode request and result/flag response bus for alu_nbit_seq.
// The master side drives operations and consumes results; the ALU is the slave.
interface alu_nbit_seq_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [3:0]       opcode;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic [WIDTH-1:0] result_hi;
    logic             zero_flag;
    logic             overflow_flag;
    logic             neg_flag;
    logic             carry_flag;
    logic             parity_flag;
    logic             busy;

    modport master (
        output in_valid, A, B, opcode, out_ready,
        input  in_ready, out_valid, result, result_hi, zero_flag,
               overflow_flag, neg_flag, carry_flag, parity_flag, busy
    );

    modport slave (
        input  in_valid, A, B, opcode, out_ready,
        output in_ready, out_valid, result, result_hi, zero_flag,
               overflow_flag, neg_flag, carry_flag, parity_flag, busy
    );
endinterface

// File: rtl/alu_nbit_seq.sv
// Handshaked WIDTH-bit ALU with registered results and flags held until consumed.
// Define ALU_MUL_EN to build the iterative WIDTH-cycle shift-add multiplier for opcode 1100.
module alu_nbit_seq #(
    parameter int WIDTH = 8
) (
    input logic           clk,
    input logic           rst,
    alu_nbit_seq_if.slave bus
);

    localparam int SHW = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_AND  = 4'b0010;
    localparam logic [3:0] OP_OR   = 4'b0011;
    localparam logic [3:0] OP_XOR  = 4'b0100;
    localparam logic [3:0] OP_INCA = 4'b0101;
    localparam logic [3:0] OP_DECA = 4'b0110;
    localparam logic [3:0] OP_INCB = 4'b0111;
    localparam logic [3:0] OP_DECB = 4'b1000;
    localparam logic [3:0] OP_LSL  = 4'b1001;
    localparam logic [3:0] OP_LSR  = 4'b1010;
    localparam logic [3:0] OP_ASR  = 4'b1011;
`ifdef ALU_MUL_EN
    localparam logic [3:0] OP_MUL  = 4'b1100;
`endif

    typedef enum logic [1:0] {
        IDLE = 2'd0,
`ifdef ALU_MUL_EN
        MUL  = 2'd1,
`endif
        DONE = 2'd2
    } state_t;

    typedef struct packed {
        logic [WIDTH-1:0] res;
        logic             carry;
        logic             ovf;
    } op_res_t;

    function automatic op_res_t add_op(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
        op_res_t    r;
        logic [WIDTH:0] s;
        s       = {1'b0, x} + {1'b0, y};
        r.res   = s[WIDTH-1:0];
        r.carry = s[WIDTH];
        r.ovf   = (x[WIDTH-1] == y[WIDTH-1]) && (s[WIDTH-1] != x[WIDTH-1]);
        return r;
    endfunction

    // Top bit of the widened difference is the unsigned borrow (x < y).
    function automatic op_res_t sub_op(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
        op_res_t    r;
        logic [WIDTH:0] d;
        d       = {1'b0, x} - {1'b0, y};
        r.res   = d[WIDTH-1:0];
        r.carry = d[WIDTH];
        r.ovf   = (x[WIDTH-1] != y[WIDTH-1]) && (d[WIDTH-1] != x[WIDTH-1]);
        return r;
    endfunction

    function automatic op_res_t eval_op(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                        input logic [3:0] op);
        op_res_t              r;
        logic [WIDTH:0]       w;
        logic signed [WIDTH:0] sw;
        logic [SHW-1:0]       sh;
        r  = '0;
        w  = '0;
        sw = '0;
        sh = y[SHW-1:0];
        case (op)
            OP_ADD:  r = add_op(x, y);
            OP_SUB:  r = sub_op(x, y);
            OP_AND:  r.res = x & y;
            OP_OR:   r.res = x | y;
            OP_XOR:  r.res = x ^ y;
            OP_INCA: r = add_op(x, ONE);
            OP_DECA: r = sub_op(x, ONE);
            OP_INCB: r = add_op(y, ONE);
            OP_DECB: r = sub_op(y, ONE);
            // Shifts run on a one-bit-wider word so the last bit out lands in the spare slot.
            OP_LSL: begin
                w       = {1'b0, x} << sh;
                r.res   = w[WIDTH-1:0];
                r.carry = w[WIDTH];
            end
            OP_LSR: begin
                w       = {x, 1'b0} >> sh;
                r.res   = w[WIDTH:1];
                r.carry = w[0];
            end
            OP_ASR: begin
                sw      = $signed({x, 1'b0}) >>> sh;
                r.res   = sw[WIDTH:1];
                r.carry = sw[0];
            end
            default: r = '0;
        endcase
        return r;
    endfunction

    state_t           state;
    state_t           state_nxt;
    state_t           accept_state;
    logic             ready;
    logic             accept;
    logic             is_mul;
    op_res_t          alu_p0;

    logic [WIDTH-1:0] result_p1;
    logic             zero_p1;
    logic             ovf_p1;
    logic             neg_p1;
    logic             carry_p1;
    logic             parity_p1;
    logic             vld_p1;

    assign alu_p0 = eval_op(bus.A, bus.B, bus.opcode);

`ifdef ALU_MUL_EN
    logic [WIDTH-1:0]   mcand_p1;
    logic [WIDTH-1:0]   result_hi_p1;
    logic [2*WIDTH-1:0] prod_p1;
    logic [2*WIDTH-1:0] prod_nxt;
    logic [SHW-1:0]     cnt_p1;
    logic [WIDTH-1:0]   addend;
    logic [WIDTH:0]     psum;
    logic               last_iter;

    assign is_mul    = (bus.opcode == OP_MUL);
    assign addend    = prod_p1[0] ? mcand_p1 : '0;
    assign psum      = {1'b0, prod_p1[2*WIDTH-1:WIDTH]} + {1'b0, addend};
    assign prod_nxt  = {psum, prod_p1[WIDTH-1:1]};
    assign last_iter = (cnt_p1 == SHW'(WIDTH - 1));

    // Multiplier stage: upper half accumulates, lower half holds remaining multiplier bits.
    always_ff @(posedge clk) begin
        if (accept && is_mul) begin
            mcand_p1 <= bus.A;
            prod_p1  <= {{WIDTH{1'b0}}, bus.B};
            cnt_p1   <= '0;
        end else if (state == MUL) begin
            prod_p1  <= prod_nxt;
            cnt_p1   <= cnt_p1 + 1'b1;
        end
    end
`else
    assign is_mul = 1'b0;
`endif

    always_comb begin
        state_nxt    = state;
        ready        = 1'b0;
`ifdef ALU_MUL_EN
        accept_state = is_mul ? MUL : DONE;
`else
        accept_state = DONE;
`endif
        case (state)
            IDLE: begin
                ready = 1'b1;
                if (bus.in_valid) state_nxt = accept_state;
            end
`ifdef ALU_MUL_EN
            MUL: begin
                if (last_iter) state_nxt = DONE;
            end
`endif
            DONE: begin
                ready = bus.out_ready;
                if (bus.out_ready) state_nxt = bus.in_valid ? accept_state : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign accept = bus.in_valid && ready;

    // Output stage: results and flags change only on a completed operation.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            result_p1    <= '0;
            zero_p1      <= 1'b0;
            ovf_p1       <= 1'b0;
            neg_p1       <= 1'b0;
            carry_p1     <= 1'b0;
            parity_p1    <= 1'b0;
`ifdef ALU_MUL_EN
            result_hi_p1 <= '0;
`endif
        end else begin
            state <= state_nxt;
            if (accept && !is_mul) begin
                result_p1    <= alu_p0.res;
                zero_p1      <= (alu_p0.res == '0);
                ovf_p1       <= alu_p0.ovf;
                neg_p1       <= alu_p0.res[WIDTH-1];
                carry_p1     <= alu_p0.carry;
                parity_p1    <= ^alu_p0.res;
`ifdef ALU_MUL_EN
                result_hi_p1 <= '0;
`endif
            end
`ifdef ALU_MUL_EN
            if (state == MUL && last_iter) begin
                result_p1    <= prod_nxt[WIDTH-1:0];
                result_hi_p1 <= prod_nxt[2*WIDTH-1:WIDTH];
                zero_p1      <= (prod_nxt == '0);
                ovf_p1       <= |prod_nxt[2*WIDTH-1:WIDTH];
                neg_p1       <= prod_nxt[WIDTH-1];
                carry_p1     <= |prod_nxt[2*WIDTH-1:WIDTH];
                parity_p1    <= ^prod_nxt[WIDTH-1:0];
            end
`endif
        end
    end

    assign vld_p1            = (state == DONE);
    assign bus.in_ready      = ready;
    assign bus.out_valid     = vld_p1;
    assign bus.result        = result_p1;
    assign bus.zero_flag     = zero_p1;
    assign bus.overflow_flag = ovf_p1;
    assign bus.neg_flag      = neg_p1;
    assign bus.carry_flag    = carry_p1;
    assign bus.parity_flag   = parity_p1;
`ifdef ALU_MUL_EN
    assign bus.result_hi     = result_hi_p1;
    assign bus.busy          = (state == MUL);
`else
    assign bus.result_hi     = '0;
    assign bus.busy          = 1'b0;
`endif

endmodule

// File: tb/tb_alu_nbit_seq.sv
// Table-driven and scoreboard bench for alu_nbit_seq at WIDTH=8, with hand sequences
// for backpressure, multiply latency and reset during an operation.
module tb_alu_nbit_seq;
    localparam int W = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    alu_nbit_seq_if #(.WIDTH(W)) bus();
    alu_nbit_seq #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct packed {
        logic [7:0] res;
        logic [7:0] hi;
        logic       z, o, n, c, p;
    } exp_t;

    typedef struct packed {
        logic [3:0] op;
        logic [7:0] a;
        logic [7:0] b;
        exp_t       e;
    } vec_t;

    exp_t sb_q[$];
    int   tag_q[$];
    vec_t vecs[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    exp_t mon_e;
    int   mon_t;

    task automatic chk(input string name, input int tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s #%0d: got %h, expected %h", name, tag, act, exp);
        end
    endtask

    function automatic exp_t mk(input logic [7:0] res, input logic [7:0] hi,
                                input logic z, input logic o, input logic n, input logic c, input logic p);
        exp_t e;
        e.res = res; e.hi = hi; e.z = z; e.o = o; e.n = n; e.c = c; e.p = p;
        return e;
    endfunction

    function automatic vec_t mv(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b, input exp_t e);
        vec_t v;
        v.op = op; v.a = a; v.b = b; v.e = e;
        return v;
    endfunction

    // Integer reference model for 8-bit operands.
    function automatic exp_t model(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
        exp_t e;
        int ia, ib, sa, sb, s, sh;
        bit full_zero_from_s;
        e = '0;
        ia = int'(a); ib = int'(b);
        sa = (ia >= 128) ? ia - 256 : ia;
        sb = (ib >= 128) ? ib - 256 : ib;
        sh = ib % 8;
        s  = 0;
        full_zero_from_s = 1'b0;
        case (op)
            4'd0: begin s = ia + ib; e.c = (s > 255); e.o = (sa + sb > 127) || (sa + sb < -128); end
            4'd1: begin s = ia - ib; e.c = (ia < ib); e.o = (sa - sb > 127) || (sa - sb < -128); end
            4'd2: s = ia & ib;
            4'd3: s = ia | ib;
            4'd4: s = ia ^ ib;
            4'd5: begin s = ia + 1; e.c = (s > 255); e.o = (sa + 1 > 127); end
            4'd6: begin s = ia - 1; e.c = (ia < 1); e.o = (sa - 1 < -128); end
            4'd7: begin s = ib + 1; e.c = (s > 255); e.o = (sb + 1 > 127); end
            4'd8: begin s = ib - 1; e.c = (ib < 1); e.o = (sb - 1 < -128); end
            4'd9: begin s = ia << sh; e.c = (sh != 0) && (((ia >> (8 - sh)) & 1) == 1); end
            4'd10: begin s = ia >> sh; e.c = (sh != 0) && (((ia >> (sh - 1)) & 1) == 1); end
            4'd11: begin s = sa >>> sh; e.c = (sh != 0) && (((ia >> (sh - 1)) & 1) == 1); end
`ifdef ALU_MUL_EN
            4'd12: begin
                s = ia * ib;
                e.hi = 8'((s >> 8) & 255);
                e.c = (e.hi != 8'd0);
                e.o = (e.hi != 8'd0);
                full_zero_from_s = 1'b1;
            end
`endif
            default: s = 0;
        endcase
        e.res = 8'(s & 255);
        e.z = full_zero_from_s ? (s == 0) : (e.res == 8'd0);
        e.n = e.res[7];
        e.p = ^e.res;
        return e;
    endfunction

    task automatic send(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                        input exp_t e, input int tag, input bit expect_out);
        int guard;
        bus.in_valid = 1'b1;
        bus.opcode   = op;
        bus.A        = a;
        bus.B        = b;
        if (expect_out) begin
            sb_q.push_back(e);
            tag_q.push_back(tag);
        end
        #1;
        guard = 0;
        while (!bus.in_ready && guard < 200) begin
            @(negedge clk); #1;
            guard++;
        end
        chk("accept_ready", tag, 32'(bus.in_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        int g;
        g = 0;
        while (sb_q.size() != 0 && g < 100) begin
            @(negedge clk);
            g++;
        end
        chk("drain", g, 32'(sb_q.size()), 32'd0);
        @(negedge clk);
    endtask

    // Result consumer: every handshake pops one expectation.
    always @(negedge clk) begin
        #2;
        if (!rst && bus.out_valid && bus.out_ready) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_output", -1, 32'(bus.out_valid), 32'd0);
            end else begin
                mon_e = sb_q.pop_front();
                mon_t = tag_q.pop_front();
                chk("result", mon_t, {16'd0, bus.result, bus.result_hi}, {16'd0, mon_e.res, mon_e.hi});
                chk("flags", mon_t,
                    {27'd0, bus.zero_flag, bus.overflow_flag, bus.neg_flag, bus.carry_flag, bus.parity_flag},
                    {27'd0, mon_e.z, mon_e.o, mon_e.n, mon_e.c, mon_e.p});
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.A         = '0;
        bus.B         = '0;
        bus.opcode    = '0;

        //           op     A      B      res    hi     z o n c p
        vecs.push_back(mv(4'h0, 8'h7F, 8'h01, mk(8'h80, 8'h00, 0, 1, 1, 0, 1)));
        vecs.push_back(mv(4'h1, 8'h04, 8'h08, mk(8'hFC, 8'h00, 0, 0, 1, 1, 0)));
        vecs.push_back(mv(4'hB, 8'h90, 8'h02, mk(8'hE4, 8'h00, 0, 0, 1, 0, 0)));
        vecs.push_back(mv(4'h9, 8'h81, 8'h01, mk(8'h02, 8'h00, 0, 0, 0, 1, 1)));
        vecs.push_back(mv(4'hA, 8'hA5, 8'h00, mk(8'hA5, 8'h00, 0, 0, 1, 0, 0)));
        vecs.push_back(mv(4'h0, 8'hFF, 8'h01, mk(8'h00, 8'h00, 1, 0, 0, 1, 0)));
        vecs.push_back(mv(4'h0, 8'h80, 8'h80, mk(8'h00, 8'h00, 1, 1, 0, 1, 0)));
        vecs.push_back(mv(4'h2, 8'hF0, 8'h3C, mk(8'h30, 8'h00, 0, 0, 0, 0, 0)));
        vecs.push_back(mv(4'h3, 8'h0F, 8'h30, mk(8'h3F, 8'h00, 0, 0, 0, 0, 0)));
        vecs.push_back(mv(4'h4, 8'hAA, 8'hFF, mk(8'h55, 8'h00, 0, 0, 0, 0, 0)));
        vecs.push_back(mv(4'h5, 8'h7F, 8'h00, mk(8'h80, 8'h00, 0, 1, 1, 0, 1)));
        vecs.push_back(mv(4'h6, 8'h00, 8'h00, mk(8'hFF, 8'h00, 0, 0, 1, 1, 0)));
        vecs.push_back(mv(4'h7, 8'h12, 8'hFF, mk(8'h00, 8'h00, 1, 0, 0, 1, 0)));
        vecs.push_back(mv(4'h8, 8'h00, 8'h80, mk(8'h7F, 8'h00, 0, 1, 0, 0, 1)));
        vecs.push_back(mv(4'h8, 8'h55, 8'h00, mk(8'hFF, 8'h00, 0, 0, 1, 1, 0)));
        vecs.push_back(mv(4'h1, 8'h80, 8'h01, mk(8'h7F, 8'h00, 0, 1, 0, 0, 1)));
        vecs.push_back(mv(4'hA, 8'hC1, 8'h07, mk(8'h01, 8'h00, 0, 0, 0, 1, 1)));
        vecs.push_back(mv(4'hB, 8'h80, 8'h07, mk(8'hFF, 8'h00, 0, 0, 1, 0, 0)));
        vecs.push_back(mv(4'h9, 8'h40, 8'h0A, mk(8'h00, 8'h00, 1, 0, 0, 1, 0)));
        vecs.push_back(mv(4'hD, 8'h12, 8'h34, mk(8'h00, 8'h00, 1, 0, 0, 0, 0)));
        vecs.push_back(mv(4'hF, 8'hFF, 8'hFF, mk(8'h00, 8'h00, 1, 0, 0, 0, 0)));
        vecs.push_back(mv(4'hC, 8'h00, 8'h37, mk(8'h00, 8'h00, 1, 0, 0, 0, 0)));
`ifdef ALU_MUL_EN
        vecs.push_back(mv(4'hC, 8'hFF, 8'hFF, mk(8'h01, 8'hFE, 0, 1, 0, 1, 1)));
        vecs.push_back(mv(4'hC, 8'h10, 8'h10, mk(8'h00, 8'h01, 0, 1, 0, 1, 0)));
        vecs.push_back(mv(4'hC, 8'h0F, 8'h0F, mk(8'hE1, 8'h00, 0, 0, 1, 0, 0)));
`else
        vecs.push_back(mv(4'hC, 8'hFF, 8'hFF, mk(8'h00, 8'h00, 1, 0, 0, 0, 0)));
        vecs.push_back(mv(4'hC, 8'h10, 8'h10, mk(8'h00, 8'h00, 1, 0, 0, 0, 0)));
`endif
        for (int i = 0; i < 24; i++) begin
            logic [3:0] rop;
            logic [7:0] ra, rb;
            rop = 4'($urandom_range(0, 15));
            ra  = 8'($urandom);
            rb  = 8'($urandom);
            vecs.push_back(mv(rop, ra, rb, model(rop, ra, rb)));
        end

        repeat (3) @(posedge clk);
        @(negedge clk); #3;
        chk("rst_in_ready", 0, 32'(bus.in_ready), 32'd1);
        chk("rst_out_valid", 0, 32'(bus.out_valid), 32'd0);
        chk("rst_busy", 0, 32'(bus.busy), 32'd0);
        chk("rst_outputs", 0,
            {11'd0, bus.result, bus.result_hi, bus.zero_flag, bus.overflow_flag,
             bus.neg_flag, bus.carry_flag, bus.parity_flag}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        bus.out_ready = 1'b1;
        for (int i = 0; i < vecs.size(); i++) begin
            send(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].e, i, 1'b1);
        end
        drain();

        // Backpressure: result held three cycles while a new op waits.
        bus.out_ready = 1'b0;
        send(4'h0, 8'h7F, 8'h01, mk(8'h80, 8'h00, 0, 1, 1, 0, 1), 100, 1'b1);
        bus.in_valid = 1'b1;
        bus.opcode   = 4'h1;
        bus.A        = 8'h04;
        bus.B        = 8'h08;
        sb_q.push_back(mk(8'hFC, 8'h00, 0, 0, 1, 1, 0));
        tag_q.push_back(101);
        for (int k = 0; k < 3; k++) begin
            #3;
            chk("bp_out_valid", k, 32'(bus.out_valid), 32'd1);
            chk("bp_in_ready", k, 32'(bus.in_ready), 32'd0);
            chk("bp_hold", k, {16'd0, bus.result, 3'd0, bus.zero_flag, bus.overflow_flag,
                               bus.neg_flag, bus.carry_flag, bus.parity_flag},
                {16'd0, 8'h80, 3'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1});
            @(negedge clk);
        end
        bus.out_ready = 1'b1;
        #1;
        chk("b2b_in_ready", 0, 32'(bus.in_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        #3;
        chk("b2b_out_valid", 0, 32'(bus.out_valid), 32'd1);
        chk("b2b_result", 0, 32'(bus.result), 32'h0000_00FC);
        drain();

`ifdef ALU_MUL_EN
        bus.in_valid = 1'b1;
        bus.opcode   = 4'hC;
        bus.A        = 8'hFF;
        bus.B        = 8'hFF;
        sb_q.push_back(mk(8'h01, 8'hFE, 0, 1, 0, 1, 1));
        tag_q.push_back(200);
        #1;
        chk("mul_accept_ready", 0, 32'(bus.in_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        for (int k = 0; k < 8; k++) begin
            #3;
            chk("mul_busy", k, 32'(bus.busy), 32'd1);
            chk("mul_in_ready", k, 32'(bus.in_ready), 32'd0);
            chk("mul_out_valid", k, 32'(bus.out_valid), 32'd0);
            @(negedge clk);
        end
        #3;
        chk("mul_done_valid", 0, 32'(bus.out_valid), 32'd1);
        chk("mul_done_busy", 0, 32'(bus.busy), 32'd0);
`else
        send(4'hC, 8'hFF, 8'hFF, mk(8'h00, 8'h00, 1, 0, 0, 0, 0), 200, 1'b1);
        #3;
        chk("mul_off_valid", 0, 32'(bus.out_valid), 32'd1);
        chk("mul_off_busy", 0, 32'(bus.busy), 32'd0);
        chk("mul_off_hi", 0, 32'(bus.result_hi), 32'd0);
`endif
        drain();

        // Reset while an operation is in flight or its result is pending.
`ifdef ALU_MUL_EN
        bus.in_valid = 1'b1;
        bus.opcode   = 4'hC;
        bus.A        = 8'h05;
        bus.B        = 8'h03;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
`else
        bus.out_ready = 1'b0;
        send(4'h0, 8'h7F, 8'h01, mk(8'h80, 8'h00, 0, 1, 1, 0, 1), 300, 1'b0);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
`endif
        #3;
        chk("mid_rst_out_valid", 0, 32'(bus.out_valid), 32'd0);
        chk("mid_rst_busy", 0, 32'(bus.busy), 32'd0);
        chk("mid_rst_in_ready", 0, 32'(bus.in_ready), 32'd1);
        chk("mid_rst_outputs", 0,
            {11'd0, bus.result, bus.result_hi, bus.zero_flag, bus.overflow_flag,
             bus.neg_flag, bus.carry_flag, bus.parity_flag}, 32'd0);
        bus.out_ready = 1'b1;
        @(negedge clk);
        send(4'hF, 8'h5A, 8'hA5, mk(8'h00, 8'h00, 1, 0, 0, 0, 0), 301, 1'b1);
        #3;
        chk("post_rst_latency", 0, 32'(bus.out_valid), 32'd1);
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
